alu_mul_sequencer: RTL
======================

// Module: alu_mul_sequencer
// PURPOSE
//   Multi-cycle unsigned shift-and-add multiplier acting as the issuing end of the ALU
//   interface. It drives BusA/BusB/ALUCtrl of an external ALU instance and consumes
//   BusW/Zero. It uses ADD for partial-product accumulation and PassB+Zero for
//   early termination. It sits beside the datapath ALU, time-sharing it for MUL-type ops.
// PARAMETERS
//   WIDTH  64  operand/result width; must equal the ALU bus width
// PORTS
//   Clk       in   1      clock; all state updates on the rising edge
//   Reset     in   1      synchronous, active-high reset
//   Start     in   1      request; sampled only while Busy==0
//   OpA       in   WIDTH  multiplicand; latched when Start is accepted
//   OpB       in   WIDTH  multiplier; latched when Start is accepted
//   Busy      out  1      high in every state except IDLE
//   Done      out  1      one-cycle pulse (DONE state); Result is valid
//   Result    out  WIDTH  low WIDTH bits of OpA*OpB; held until the next accepted Start
//   AluBusA   out  WIDTH  to ALU BusA
//   AluBusB   out  WIDTH  to ALU BusB
//   AluCtrl   out  4      to ALU ALUCtrl (0000 AND, 0010 ADD, 0111 PassB)
//   AluBusW   in   WIDTH  from ALU BusW (combinational, same cycle)
//   AluZero   in   1      from ALU Zero
// BEHAVIOUR
//   Reset: state=IDLE; Busy=0, Done=0, Result=0; internal mcand/mplier/count=0.
//     Reset overrides everything, including mid-operation (the op is abandoned, no Done).
//   Regs: prod, mcand, mplier (WIDTH each), count (clog2(WIDTH)+1 bits).
//   Default ALU drive (IDLE, SHIFT, DONE): AluCtrl=0000, AluBusA=0, AluBusB=0.
//   FSM:
//     IDLE : Start=1 -> mcand<=OpA, mplier<=OpB, prod<=0, count<=0; go CHECK.
//     CHECK: drive AluCtrl=0111, AluBusB=mplier, AluBusA=0.
//            AluZero=1 or count==WIDTH -> DONE; else mplier[0]=1 -> ADD; else -> SHIFT.
//     ADD  : drive AluCtrl=0010, AluBusA=prod, AluBusB=mcand; prod<=AluBusW; -> SHIFT.
//     SHIFT: mcand<=mcand<<1, mplier<=mplier>>1, count<=count+1; -> CHECK.
//     DONE : Result<=prod (registered on entry, visible while Done=1); Done=1; -> IDLE.
//   Result register: written on the edge entering DONE; unchanged otherwise.
//   Arithmetic: modulo 2^WIDTH. Bits shifted out of mcand are discarded; no overflow flag.
//   Latency: the Start-accepting edge is cycle 0. Done is high in cycle 2*L+P+2, where
//     L = bit length of OpB and P = popcount(OpB).
//     Examples: OpB=0 -> 2; OpB=all ones -> 194 (maximum).
//   Start while Busy=1: ignored; it is not queued and does not alter latched operands.
//   Start in the DONE cycle: ignored. Start is accepted on or after the following IDLE cycle.
//   Start held high continuously: a new op is accepted every time the FSM returns to IDLE.
//   Done and Busy are never simultaneously low->high glitch-free issues: both are registered or
//     decoded from the registered state only.
// TESTING
//   1. OpA=3, OpB=5, Start 1 cycle -> Done in cycle 10, Result=15; AluCtrl=0010 seen exactly 2x.
//   2. OpA=0x1234, OpB=0 -> Done in cycle 2, Result=0; ADD never issued.
//   3. OpA=64'hFFFF_FFFF_FFFF_FFFF, OpB=2 -> Result=64'hFFFF_FFFF_FFFF_FFFE (wrap); Done cycle 7.
//   4. OpA=7, OpB=all ones -> Done in cycle 194, Result=64'hFFFF_FFFF_FFFF_FFF9.
//   5. Start op (6*7); pulse Start with OpA=9, OpB=9 at cycle 3 -> Result=42; second Start ignored.
//   6. Reset at cycle 4 of 3*5 -> next cycle Busy=0, Done=0, Result=0; new 2*2 -> Result=4.

Source files
------------

// File: rtl/alu_mul_sequencer_if.sv
// Bundles the multiplier's request/response pins and the ALU issue pins between the
// sequencer (slave) and whoever supplies operands and the ALU (master).
interface alu_mul_sequencer_if #(
    parameter int WIDTH = 64
);
    logic             Start;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] AluBusA;
    logic [WIDTH-1:0] AluBusB;
    logic [3:0]       AluCtrl;
    logic [WIDTH-1:0] AluBusW;
    logic             AluZero;

    modport slave (
        input  Start, OpA, OpB, AluBusW, AluZero,
        output Busy, Done, Result, AluBusA, AluBusB, AluCtrl
    );

    modport master (
        output Start, OpA, OpB, AluBusW, AluZero,
        input  Busy, Done, Result, AluBusA, AluBusB, AluCtrl
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier that borrows an external ALU: ADD accumulates
// partial products, PassB of the remaining multiplier lets Zero end the loop early.
module alu_mul_sequencer #(
    parameter int WIDTH = 64
) (
    input  logic                 Clk,
    input  logic                 Reset,
    alu_mul_sequencer_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] prod_reg, prod_next;
    logic [WIDTH-1:0] mcand_reg, mcand_next;
    logic [WIDTH-1:0] mplier_reg, mplier_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] result_reg, result_next;

    logic [WIDTH-1:0] alu_a, alu_b;
    logic [3:0]       alu_ctrl;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg  <= S_IDLE;
            prod_reg   <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            prod_reg   <= prod_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            count_reg  <= count_next;
            result_reg <= result_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        prod_next   = prod_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        count_next  = count_reg;
        result_next = result_reg;
        alu_a       = '0;
        alu_b       = '0;
        alu_ctrl    = ALU_AND;

        case (state_reg)
            S_IDLE: begin
                if (bus.Start) begin
                    mcand_next  = bus.OpA;
                    mplier_next = bus.OpB;
                    prod_next   = '0;
                    count_next  = '0;
                    state_next  = S_CHECK;
                end
            end
            S_CHECK: begin
                // Zero from PassB means no multiplier bits remain, so stop early
                alu_ctrl = ALU_PASSB;
                alu_b    = mplier_reg;
                if (bus.AluZero || (count_reg == CW'(WIDTH))) begin
                    result_next = prod_reg;
                    state_next  = S_DONE;
                end else if (mplier_reg[0]) begin
                    state_next = S_ADD;
                end else begin
                    state_next = S_SHIFT;
                end
            end
            S_ADD: begin
                alu_ctrl   = ALU_ADD;
                alu_a      = prod_reg;
                alu_b      = mcand_reg;
                prod_next  = bus.AluBusW;
                state_next = S_SHIFT;
            end
            S_SHIFT: begin
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                count_next  = count_reg + CW'(1);
                state_next  = S_CHECK;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign bus.Busy    = (state_reg != S_IDLE);
    assign bus.Done    = (state_reg == S_DONE);
    assign bus.Result  = result_reg;
    assign bus.AluBusA = alu_a;
    assign bus.AluBusB = alu_b;
    assign bus.AluCtrl = alu_ctrl;
endmodule
